// File: rtl/std_sram_singleport_arb2_if.sv
`default_nettype none
// ============================================================================
// Module   : std_sram_singleport_arb2_if
// Purpose  : Request/response and SRAM-side bundle for the two-client arbiter.
// Revision : 1.0
// ============================================================================
interface std_sram_singleport_arb2_if #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic                  req0_we;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_din;

  logic                  req1_valid;
  logic                  req1_ready;
  logic                  req1_we;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_din;

  logic                  resp0_valid;
  logic                  resp1_valid;
  logic [DATA_WIDTH-1:0] resp_data;

  logic                  sram_en;
  logic                  sram_we;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_din;
  logic [DATA_WIDTH-1:0] sram_dout;

  // Environment side: clients plus the SRAM array model.
  modport master (
    output req0_valid, req0_we, req0_addr, req0_din,
    output req1_valid, req1_we, req1_addr, req1_din,
    output sram_dout,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp1_valid, resp_data,
    input  sram_en, sram_we, sram_addr, sram_din
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_din,
    input  req1_valid, req1_we, req1_addr, req1_din,
    input  sram_dout,
    output req0_ready, req1_ready,
    output resp0_valid, resp1_valid, resp_data,
    output sram_en, sram_we, sram_addr, sram_din
  );
endinterface : std_sram_singleport_arb2_if
`default_nettype wire

// File: rtl/std_sram_singleport_arb2.sv
`default_nettype none
// ============================================================================
// Module   : std_sram_singleport_arb2
// Purpose  : Two-client arbiter/sequencer for a registered-output single-port
//            SRAM. Define STD_SRAM_ARB2_ROUND_ROBIN_EN for round-robin
//            arbitration; otherwise requester 0 has fixed priority.
// Revision : 1.0
// ============================================================================
module std_sram_singleport_arb2 #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       aregrst,
  std_sram_singleport_arb2_if.slave  bus
);

  logic                  grant0;
  logic                  grant1;
  logic                  granted;
  logic                  we_sel;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [DATA_WIDTH-1:0] din_sel;

  logic [1:0]            rd_vld_q;
  logic [1:0]            rd_vld_d;
  logic [1:0]            rd_id_q;
  logic [1:0]            rd_id_d;

`ifdef STD_SRAM_ARB2_ROUND_ROBIN_EN
  // prio_q names the requester that wins the next simultaneous request.
  logic prio_q;
  logic prio_d;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (aregrst) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = ~prio_q;
        grant1 = prio_q;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
    prio_d = prio_q;
    if (grant0) begin
      prio_d = 1'b1;
    end else if (grant1) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge aregrst) begin
    if (!aregrst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end
`else
  always_comb begin
    grant0 = aregrst & bus.req0_valid;
    grant1 = aregrst & bus.req1_valid & ~bus.req0_valid;
  end
`endif

  // Grants are masked during reset so nothing reaches the array while held.
  always_comb begin
    granted  = grant0 | grant1;
    we_sel   = 1'b0;
    addr_sel = '0;
    din_sel  = '0;
    if (grant0) begin
      we_sel   = bus.req0_we;
      addr_sel = bus.req0_addr;
      din_sel  = bus.req0_din;
    end else if (grant1) begin
      we_sel   = bus.req1_we;
      addr_sel = bus.req1_addr;
      din_sel  = bus.req1_din;
    end
  end

  always_comb begin
    rd_vld_d    = {rd_vld_q[0], granted & ~we_sel};
    rd_id_d     = {rd_id_q[0], grant1};
  end

  // Two stages match the array read plus its output register.
  always_ff @(posedge clk or negedge aregrst) begin
    if (!aregrst) begin
      rd_vld_q <= 2'b00;
      rd_id_q  <= 2'b00;
    end else begin
      rd_vld_q <= rd_vld_d;
      rd_id_q  <= rd_id_d;
    end
  end

  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;
  assign bus.sram_en     = granted;
  assign bus.sram_we     = we_sel;
  assign bus.sram_addr   = addr_sel;
  assign bus.sram_din    = din_sel;
  assign bus.resp0_valid = rd_vld_q[1] & ~rd_id_q[1];
  assign bus.resp1_valid = rd_vld_q[1] &  rd_id_q[1];
  assign bus.resp_data   = bus.sram_dout;

endmodule : std_sram_singleport_arb2
`default_nettype wire
